ps2_entry_ctrl: RTL and testbench

Sequencing controller between the PS/2 frame receiver and the 8-digit seven-segment scan driver. It consumes raw scan-code bytes and tracks make, break and extended prefixes. It edits an 8-digit decimal entry buffer (digit keys, backspace, escape, enter) and presents the buffer and a blank mask to the display driver, plus a committed value to downstream logic.

---
 rtl/ps2_entry_pkg.sv | 40 ++++
 rtl/ps2_digit_decode.sv | 45 ++++
 rtl/ps2_entry_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_ps2_entry_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_entry_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_entry_pkg
// Description : Shared scan-code constants and byte-sequencer state type for
//               the PS/2 decimal entry controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_entry_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Editing keys (set 2 make codes)
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Digit keys 0..9 on the main key row
  localparam logic [7:0] SC_D0 = 8'h45;
  localparam logic [7:0] SC_D1 = 8'h16;
  localparam logic [7:0] SC_D2 = 8'h1E;
  localparam logic [7:0] SC_D3 = 8'h26;
  localparam logic [7:0] SC_D4 = 8'h25;
  localparam logic [7:0] SC_D5 = 8'h2E;
  localparam logic [7:0] SC_D6 = 8'h36;
  localparam logic [7:0] SC_D7 = 8'h3D;
  localparam logic [7:0] SC_D8 = 8'h3E;
  localparam logic [7:0] SC_D9 = 8'h46;

  // Byte sequencer: where we are inside a make / break / extended sequence
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_e;

endpackage : ps2_entry_pkg
`default_nettype wire

// File: rtl/ps2_digit_decode.sv
`default_nettype none
// ============================================================================
// Module      : ps2_digit_decode
// Description : Combinational classifier of a make code into digit / enter /
//               backspace / escape. Unknown codes assert no flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_digit_decode
  import ps2_entry_pkg::*;
(
  input  logic [7:0] code_i,
  output logic       is_digit_o,
  output logic [3:0] digit_o,
  output logic       is_enter_o,
  output logic       is_bksp_o,
  output logic       is_esc_o
);

  // Classify the code; every output defaulted so nothing latches
  always_comb begin
    is_digit_o = 1'b0;
    digit_o    = 4'h0;
    is_enter_o = 1'b0;
    is_bksp_o  = 1'b0;
    is_esc_o   = 1'b0;
    case (code_i)
      SC_D0:    begin is_digit_o = 1'b1; digit_o = 4'd0; end
      SC_D1:    begin is_digit_o = 1'b1; digit_o = 4'd1; end
      SC_D2:    begin is_digit_o = 1'b1; digit_o = 4'd2; end
      SC_D3:    begin is_digit_o = 1'b1; digit_o = 4'd3; end
      SC_D4:    begin is_digit_o = 1'b1; digit_o = 4'd4; end
      SC_D5:    begin is_digit_o = 1'b1; digit_o = 4'd5; end
      SC_D6:    begin is_digit_o = 1'b1; digit_o = 4'd6; end
      SC_D7:    begin is_digit_o = 1'b1; digit_o = 4'd7; end
      SC_D8:    begin is_digit_o = 1'b1; digit_o = 4'd8; end
      SC_D9:    begin is_digit_o = 1'b1; digit_o = 4'd9; end
      SC_ENTER: is_enter_o = 1'b1;
      SC_BKSP:  is_bksp_o  = 1'b1;
      SC_ESC:   is_esc_o   = 1'b1;
      default:  ;
    endcase
  end

endmodule : ps2_digit_decode
`default_nettype wire

// File: rtl/ps2_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ps2_entry_ctrl
// Description : Consumes raw PS/2 scan-code bytes, tracks break/extended
//               prefixes with a timeout, and edits an 8-digit decimal entry
//               buffer (digits, backspace, escape, enter) for a 7-segment
//               scan driver. Enter commits a snapshot of the buffer.
// Config      : PS2_ENTRY_AUTOREPEAT_EN - when defined, typematic repeats
//               are acted on and the hold register is not built.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_entry_ctrl
  import ps2_entry_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  code_in_i,
  input  logic        code_valid_i,
  output logic [31:0] digits_o,
  output logic [7:0]  blank_o,
  output logic [3:0]  len_o,
  output logic        commit_o,
  output logic [31:0] commit_digits_o,
  output logic        overflow_o
);

  localparam int                 c_CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]         c_LEN_MAX = 4'd8;

  state_e             state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] digits_q;
  logic [7:0]  blank_q;
  logic [3:0]  len_q;
  logic        commit_q;
  logic [31:0] commit_digits_q;
  logic        overflow_q;

  logic       w_make_valid;   // byte is a make code seen in IDLE
  logic       w_brk_valid;    // byte completes a break sequence
  logic       w_ext_enter;    // keypad Enter (E0 5A)
  logic       w_key_accept;   // decoded make that is acted on
  logic       w_is_digit;
  logic [3:0] w_digit;
  logic       w_is_enter;
  logic       w_is_bksp;
  logic       w_is_esc;
  logic       w_dec_any;
  logic       w_do_digit;
  logic       w_do_bksp;
  logic       w_do_esc;
  logic       w_do_enter;

  ps2_digit_decode u_decode (
    .code_i     (code_in_i),
    .is_digit_o (w_is_digit),
    .digit_o    (w_digit),
    .is_enter_o (w_is_enter),
    .is_bksp_o  (w_is_bksp),
    .is_esc_o   (w_is_esc)
  );

  assign w_dec_any = w_is_digit | w_is_enter | w_is_bksp | w_is_esc;

  // Byte sequencer and prefix timeout: next state and byte classification
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    w_make_valid = 1'b0;
    w_brk_valid  = 1'b0;
    w_ext_enter  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (code_valid_i) begin
          if (code_in_i == SC_BREAK)    state_d = ST_BRK;
          else if (code_in_i == SC_EXT) state_d = ST_EXT;
          else                          w_make_valid = 1'b1;
        end
      end
      ST_BRK, ST_EXT_BRK: begin
        if (code_valid_i) begin
          w_brk_valid = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_EXT: begin
        if (code_valid_i) begin
          if (code_in_i == SC_BREAK) begin
            state_d = ST_EXT_BRK;
          end else begin
            w_ext_enter = (code_in_i == SC_ENTER);
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A valid byte always restarts the wait; on the expiry cycle it still
    // wins because the prefix state above already consumed it.
    if (code_valid_i) begin
      cnt_d = '0;
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == c_CNT_MAX) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Sequencer state and timeout counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PS2_ENTRY_AUTOREPEAT_EN
  assign w_key_accept = w_make_valid & w_dec_any;
`else
  logic [7:0] held_code_q;
  logic       held_q;
  logic       w_repeat_hit;

  assign w_repeat_hit = held_q & (code_in_i == held_code_q);
  assign w_key_accept = w_make_valid & w_dec_any & ~w_repeat_hit;

  // Hold register: remembers the key being held to swallow typematic repeats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_code_q <= 8'h00;
      held_q      <= 1'b0;
    end else if (w_key_accept) begin
      held_code_q <= code_in_i;
      held_q      <= 1'b1;
    end else if (w_brk_valid && w_repeat_hit) begin
      held_q      <= 1'b0;
    end
  end
`endif

  assign w_do_digit = w_key_accept & w_is_digit;
  assign w_do_bksp  = w_key_accept & w_is_bksp;
  assign w_do_esc   = w_key_accept & w_is_esc;
  assign w_do_enter = (w_key_accept & w_is_enter) | w_ext_enter;

  // Entry buffer edits; commit and overflow are single-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q        <= 32'h0;
      blank_q         <= 8'hFF;
      len_q           <= 4'd0;
      commit_q        <= 1'b0;
      commit_digits_q <= 32'h0;
      overflow_q      <= 1'b0;
    end else begin
      commit_q   <= 1'b0;
      overflow_q <= 1'b0;
      if (w_do_digit) begin
        if (len_q < c_LEN_MAX) begin
          digits_q <= {digits_q[27:0], w_digit};
          blank_q  <= {blank_q[6:0], 1'b0};
          len_q    <= len_q + 4'd1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (w_do_bksp) begin
        if (len_q != 4'd0) begin
          digits_q <= {4'h0, digits_q[31:4]};
          blank_q  <= {1'b1, blank_q[7:1]};
          len_q    <= len_q - 4'd1;
        end
      end else if (w_do_esc) begin
        digits_q <= 32'h0;
        blank_q  <= 8'hFF;
        len_q    <= 4'd0;
      end else if (w_do_enter) begin
        if (len_q != 4'd0) begin
          commit_q        <= 1'b1;
          commit_digits_q <= digits_q;
          digits_q        <= 32'h0;
          blank_q         <= 8'hFF;
          len_q           <= 4'd0;
        end
      end
    end
  end

  assign digits_o        = digits_q;
  assign blank_o         = blank_q;
  assign len_o           = len_q;
  assign commit_o        = commit_q;
  assign commit_digits_o = commit_digits_q;
  assign overflow_o      = overflow_q;

endmodule : ps2_entry_ctrl
`default_nettype wire

// File: tb/tb_ps2_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_entry_ctrl
// Description : Directed self-checking bench for ps2_entry_ctrl with a short
//               prefix timeout. Expected values are hand-derived constants.
// Config      : PS2_ENTRY_AUTOREPEAT_EN selects the matching expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_entry_ctrl;

  localparam int c_TO = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  code_in;
  logic        code_valid;
  logic [31:0] digits;
  logic [7:0]  blank;
  logic [3:0]  len;
  logic        commit;
  logic [31:0] commit_digits;
  logic        overflow;

  int n_cmp;
  int n_err;

  ps2_entry_ctrl #(.TIMEOUT_CYC(c_TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .code_in_i       (code_in),
    .code_valid_i    (code_valid),
    .digits_o        (digits),
    .blank_o         (blank),
    .len_o           (len),
    .commit_o        (commit),
    .commit_digits_o (commit_digits),
    .overflow_o      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte for exactly one edge; returns #1 after that edge.
  // Consecutive calls therefore give back-to-back strobes.
  task automatic send(input logic [7:0] b);
    code_in    = b;
    code_valid = 1'b1;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_digits"}, digits, 32'h0);
    chk({tag, "_blank"}, {24'h0, blank}, 32'hFF);
    chk({tag, "_len"}, {28'h0, len}, 32'h0);
    chk({tag, "_commit"}, {31'h0, commit}, 32'h0);
    chk({tag, "_cdig"}, commit_digits, 32'h0);
    chk({tag, "_ovf"}, {31'h0, overflow}, 32'h0);
  endtask

  logic [7:0] dcode [0:8];

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    code_in    = 8'h00;
    code_valid = 1'b0;
    dcode[0] = 8'h16; dcode[1] = 8'h1E; dcode[2] = 8'h26;
    dcode[3] = 8'h25; dcode[4] = 8'h2E; dcode[5] = 8'h36;
    dcode[6] = 8'h3D; dcode[7] = 8'h3E; dcode[8] = 8'h46;
    idle(2);
    rst = 1'b0;
    idle(1);
    chk_reset_vals("rst");

    // Two digits with releases
    send(8'h16); send(8'hF0); send(8'h16);
    send(8'h1E); send(8'hF0); send(8'h1E);
    chk("two_digits", digits, 32'h00000012);
    chk("two_len", {28'h0, len}, 32'd2);
    chk("two_blank", {24'h0, blank}, 32'hFC);

    // Typematic repeat of '1'
    do_reset();
    send(8'h16); send(8'h16); send(8'h16);
`ifdef PS2_ENTRY_AUTOREPEAT_EN
    chk("rep_len", {28'h0, len}, 32'd3);
    chk("rep_digits", digits, 32'h00000111);
`else
    chk("rep_len", {28'h0, len}, 32'd1);
    chk("rep_digits", digits, 32'h00000001);
`endif

    // Fill to eight, ninth overflows
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(dcode[i]); send(8'hF0); send(dcode[i]);
    end
    chk("full_digits", digits, 32'h12345678);
    chk("full_blank", {24'h0, blank}, 32'h00);
    send(dcode[8]);
    chk("ovf_pulse", {31'h0, overflow}, 32'd1);
    chk("ovf_digits", digits, 32'h12345678);
    chk("ovf_len", {28'h0, len}, 32'd8);
    send(8'hF0);
    chk("ovf_drop", {31'h0, overflow}, 32'd0);
    send(dcode[8]);

    // Backspace then keypad Enter
    do_reset();
    send(8'h16); send(8'hF0); send(8'h16);
    send(8'h1E); send(8'hF0); send(8'h1E);
    send(8'h66);
    chk("bksp_digits", digits, 32'h00000001);
    chk("bksp_len", {28'h0, len}, 32'd1);
    chk("bksp_blank", {24'h0, blank}, 32'hFE);
    send(8'hE0); send(8'h5A);
    chk("ent_commit", {31'h0, commit}, 32'd1);
    chk("ent_cdig", commit_digits, 32'h00000001);
    chk("ent_digits", digits, 32'h0);
    chk("ent_blank", {24'h0, blank}, 32'hFF);
    chk("ent_len", {28'h0, len}, 32'd0);
    idle(1);
    chk("ent_pulse_end", {31'h0, commit}, 32'd0);

    // Escape, backspace and Enter on an empty buffer
    do_reset();
    send(8'h16); send(8'h26);
    chk("esc_pre", digits, 32'h00000013);
    send(8'h76);
    chk("esc_digits", digits, 32'h0);
    chk("esc_blank", {24'h0, blank}, 32'hFF);
    send(8'h66);
    chk("bksp0_len", {28'h0, len}, 32'd0);
    send(8'h5A);
    chk("ent0_commit", {31'h0, commit}, 32'd0);

    // Prefix timeout: full wait returns to IDLE
    do_reset();
    send(8'hF0);
    idle(c_TO);
    send(8'h16);
    chk("to_digit", digits, 32'h00000001);
    chk("to_len", {28'h0, len}, 32'd1);

    // Byte on the expiry cycle is still a break, and releases the hold
    do_reset();
    send(8'h16);
    send(8'hF0);
    idle(c_TO - 1);
    send(8'h16);
    chk("exp_brk_len", {28'h0, len}, 32'd1);
    send(8'h16);
    chk("exp_remake", digits, 32'h00000011);

    // Timed-out break leaves the hold in place
    do_reset();
    send(8'h1E);
    send(8'hF0);
    idle(c_TO);
    send(8'h1E);
`ifdef PS2_ENTRY_AUTOREPEAT_EN
    chk("to_hold_len", {28'h0, len}, 32'd2);
`else
    chk("to_hold_len", {28'h0, len}, 32'd1);
`endif

    // Reset between prefix and its byte
    do_reset();
    send(8'h16);
    send(8'hE0);
    do_reset();
    send(8'h5A);
    chk_reset_vals("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ps2_entry_ctrl
`default_nettype wire
